// File: rtl/traffic_sequencer.sv
// Burst controller for the AXI-Stream traffic generator: sequences enable/freerun,
// marks the last beat, repeats bursts after an idle gap and counts beats/stalls.
module traffic_sequencer #(
    parameter int GAP_CYCLES = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    input  logic [CNT_WIDTH-1:0] len,
    input  logic                 repeat_en,
    input  logic                 freerun_mode,
    input  logic                 axis_tvalid,
    input  logic                 axis_tready,
    output logic                 gen_enable,
    output logic                 gen_freerun,
    output logic                 axis_tlast,
    output logic                 busy,
    output logic                 done,
    output logic                 aborted,
    output logic [CNT_WIDTH-1:0] beat_count,
    output logic [CNT_WIDTH-1:0] stall_count
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE, GAP} state_t;

    state_t               state;
    logic [CNT_WIDTH-1:0] len_q;
    logic                 repeat_q;
    logic                 freerun_q;
    logic [GW-1:0]        gap_cnt;

    logic beat;
    logic stall;

    assign beat       = axis_tvalid & axis_tready;
    assign stall      = axis_tvalid & ~axis_tready;
    assign axis_tlast = (state == RUN) && (beat_count == len_q - CNT_ONE);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            len_q       <= '0;
            repeat_q    <= 1'b0;
            freerun_q   <= 1'b0;
            gap_cnt     <= '0;
            gen_enable  <= 1'b0;
            gen_freerun <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
            beat_count  <= '0;
            stall_count <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && len != '0) begin
                        len_q       <= len;
                        repeat_q    <= repeat_en;
                        freerun_q   <= freerun_mode;
                        beat_count  <= '0;
                        stall_count <= '0;
                        aborted     <= 1'b0;
                        gen_enable  <= 1'b1;
                        gen_freerun <= freerun_mode;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    if (beat)
                        beat_count <= beat_count + CNT_ONE;
                    if (stall && stall_count != '1)
                        stall_count <= stall_count + CNT_ONE;
                    if ((beat && axis_tlast) || stop) begin
                        // A final beat landing with stop counts as a normal finish
                        if (!(beat && axis_tlast))
                            aborted <= 1'b1;
                        gen_enable  <= 1'b0;
                        gen_freerun <= 1'b0;
                        done        <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (repeat_q && !aborted && !stop) begin
                        gap_cnt <= GAP_LOAD;
                        state   <= GAP;
                    end else begin
                        state <= IDLE;
                    end
                end
                GAP: begin
                    if (stop) begin
                        state <= IDLE;
                    end else if (gap_cnt == '0) begin
                        beat_count  <= '0;
                        gen_enable  <= 1'b1;
                        gen_freerun <= freerun_q;
                        state       <= RUN;
                    end else begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_traffic_sequencer.sv
// Directed bench for traffic_sequencer with a tiny generator model that
// restarts its data at 0 whenever enable is low.
module tb_traffic_sequencer;

    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset, start, stop, repeat_en, freerun_mode;
    logic [CW-1:0] len;
    logic          axis_tvalid, axis_tready, src_valid;
    logic          gen_enable, gen_freerun, axis_tlast, busy, done, aborted;
    logic [CW-1:0] beat_count, stall_count;
    logic [CW-1:0] data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    traffic_sequencer #(.GAP_CYCLES(3), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .len(len),
        .repeat_en(repeat_en), .freerun_mode(freerun_mode),
        .axis_tvalid(axis_tvalid), .axis_tready(axis_tready),
        .gen_enable(gen_enable), .gen_freerun(gen_freerun), .axis_tlast(axis_tlast),
        .busy(busy), .done(done), .aborted(aborted),
        .beat_count(beat_count), .stall_count(stall_count)
    );

    assign axis_tvalid = gen_enable & src_valid;

    always @(posedge clk) begin
        if (!gen_enable)                    data <= '0;
        else if (axis_tvalid && axis_tready) data <= data + 8'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; len = '0;
        repeat_en = 1'b0; freerun_mode = 1'b0; axis_tready = 1'b1; src_valid = 1'b1;
        step(); step();
        chk("rst_gen_enable", 32'(gen_enable), 0);
        chk("rst_gen_freerun", 32'(gen_freerun), 0);
        chk("rst_tlast", 32'(axis_tlast), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_aborted", 32'(aborted), 0);
        chk("rst_beats", 32'(beat_count), 0);
        chk("rst_stalls", 32'(stall_count), 0);
        reset = 1'b0;
        step();

        // start with len 0 is ignored
        len = 8'd0; start = 1'b1;
        step();
        start = 1'b0;
        chk("len0_busy", 32'(busy), 0);
        chk("len0_enable", 32'(gen_enable), 0);

        // basic burst of 4
        len = 8'd4; start = 1'b1;
        step();
        start = 1'b0;
        chk("basic_busy", 32'(busy), 1);
        chk("basic_enable", 32'(gen_enable), 1);
        for (int i = 0; i < 4; i++) begin
            chk("basic_data", 32'(data), 32'(i));
            chk("basic_tlast", 32'(axis_tlast), (i == 3) ? 1 : 0);
            step();
        end
        chk("basic_done", 32'(done), 1);
        chk("basic_enable_off", 32'(gen_enable), 0);
        chk("basic_beats", 32'(beat_count), 4);
        chk("basic_stalls", 32'(stall_count), 0);
        chk("basic_busy_done", 32'(busy), 1);
        step();
        chk("basic_done_pulse", 32'(done), 0);
        chk("basic_busy_drop", 32'(busy), 0);

        // backpressure on the last beat
        len = 8'd3; start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        chk("bp_data2", 32'(data), 2);
        axis_tready = 1'b0;
        chk("bp_tlast_s0", 32'(axis_tlast), 1);
        step();
        chk("bp_tlast_s1", 32'(axis_tlast), 1);
        step();
        axis_tready = 1'b1;
        chk("bp_tlast_hs", 32'(axis_tlast), 1);
        chk("bp_data_hold", 32'(data), 2);
        step();
        chk("bp_done", 32'(done), 1);
        chk("bp_stalls", 32'(stall_count), 2);
        chk("bp_beats", 32'(beat_count), 3);
        step();

        // abort after 10 beats
        len = 8'd100; start = 1'b1;
        step();
        start = 1'b0;
        repeat (10) step();
        chk("ab_beats_pre", 32'(beat_count), 10);
        axis_tready = 1'b0; stop = 1'b1;
        step();
        stop = 1'b0; axis_tready = 1'b1;
        chk("ab_done", 32'(done), 1);
        chk("ab_aborted", 32'(aborted), 1);
        chk("ab_beats", 32'(beat_count), 10);
        chk("ab_enable", 32'(gen_enable), 0);
        step();
        chk("ab_done_once", 32'(done), 0);
        chk("ab_idle", 32'(busy), 0);
        chk("ab_sticky", 32'(aborted), 1);

        // final beat coinciding with stop
        len = 8'd2; start = 1'b1;
        step();
        start = 1'b0;
        chk("co_abort_clr", 32'(aborted), 0);
        step();
        chk("co_tlast", 32'(axis_tlast), 1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("co_done", 32'(done), 1);
        chk("co_aborted", 32'(aborted), 0);
        chk("co_beats", 32'(beat_count), 2);
        step();
        chk("co_idle", 32'(busy), 0);

        // repeat mode, gap of 3
        len = 8'd2; repeat_en = 1'b1; start = 1'b1;
        step();
        start = 1'b0; repeat_en = 1'b0;
        chk("rp_b0_data0", 32'(data), 0);
        step();
        chk("rp_b0_data1", 32'(data), 1);
        step();
        chk("rp_done", 32'(done), 1);
        for (int i = 0; i < 4; i++) begin
            chk("rp_gap_enable", 32'(gen_enable), 0);
            chk("rp_gap_busy", 32'(busy), 1);
            step();
        end
        chk("rp_b1_enable", 32'(gen_enable), 1);
        chk("rp_b1_data0", 32'(data), 0);
        chk("rp_b1_beats", 32'(beat_count), 0);
        step();
        chk("rp_b1_data1", 32'(data), 1);
        step();
        chk("rp_done2", 32'(done), 1);
        step();
        chk("rp_gap2", 32'(gen_enable), 0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("rp_stop_idle", 32'(busy), 0);
        chk("rp_stop_nodone", 32'(done), 0);
        chk("rp_stop_noabort", 32'(aborted), 0);
        step();
        chk("rp_stays_idle", 32'(gen_enable), 0);

        // asynchronous reset mid-burst
        len = 8'd3; start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        chk("ar_tlast_pre", 32'(axis_tlast), 1);
        #2 reset = 1'b1;
        #1;
        chk("ar_enable", 32'(gen_enable), 0);
        chk("ar_busy", 32'(busy), 0);
        chk("ar_tlast", 32'(axis_tlast), 0);
        chk("ar_beats", 32'(beat_count), 0);
        step();
        reset = 1'b0;
        step();

        // freerun with tready stuck low saturates stall count
        len = 8'd5; freerun_mode = 1'b1; axis_tready = 1'b0; start = 1'b1;
        step();
        start = 1'b0; freerun_mode = 1'b0;
        chk("fr_freerun", 32'(gen_freerun), 1);
        repeat (300) step();
        chk("fr_stall_sat", 32'(stall_count), 32'hFF);
        chk("fr_beats", 32'(beat_count), 0);
        chk("fr_busy", 32'(busy), 1);
        stop = 1'b1;
        step();
        stop = 1'b0; axis_tready = 1'b1;
        chk("fr_freerun_off", 32'(gen_freerun), 0);
        step();
        chk("fr_idle", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
